// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU issue queue: opcode values, entry field
// widths and offsets, and the memory-ordering conflict check.
package lsu_pkg;

    localparam logic [31:0] OP_NOP = 32'd0;
    localparam logic [31:0] OP_LDI = 32'd10;
    localparam logic [31:0] OP_LD  = 32'd11;
    localparam logic [31:0] OP_ST  = 32'd12;

    localparam int unsigned ADDR_W_DEF  = 32'd16;
    localparam int unsigned WB_W_DEF    = 32'd5;
    localparam int unsigned OP_W_DEF    = 32'd7;

    // Entry layout, MSB first: {isWb, wbAddress, opCode, pOperand, sOperand}
    function automatic int unsigned entryWidth(input int unsigned addrW, input int unsigned wbW, input int unsigned opW);
        return 32'd1 + wbW + opW + 32'd2 * addrW;
    endfunction

    function automatic int unsigned pOperandOffset(input int unsigned addrW);
        return addrW;
    endfunction

    function automatic int unsigned opCodeOffset(input int unsigned addrW);
        return 32'd2 * addrW;
    endfunction

    function automatic int unsigned wbAddressOffset(input int unsigned addrW, input int unsigned opW);
        return 32'd2 * addrW + opW;
    endfunction

    function automatic int unsigned isWbOffset(input int unsigned addrW, input int unsigned opW, input int unsigned wbW);
        return 32'd2 * addrW + opW + wbW;
    endfunction

    localparam int unsigned ENTRY_W_DEF = entryWidth(ADDR_W_DEF, WB_W_DEF, OP_W_DEF);

    function automatic logic isMemOp(input logic [31:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // Two memory ops to the same address must not issue together if either writes.
    function automatic logic hasConflict(input logic [31:0] opOld, input logic [31:0] opYoung, input logic sameAddr);
        return isMemOp(opOld) && isMemOp(opYoung) && sameAddr && ((opOld == OP_ST) || (opYoung == OP_ST));
    endfunction

endpackage

// File: rtl/lsu_fifo.sv
// Circular buffer for the LSU issue queue: one push and 0/1/2 pops per edge,
// exposing the head and head+1 entries plus the occupancy count.
module lsu_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 45
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic [1:0]               popCount,
    output logic [WIDTH-1:0]         headData,
    output logic [WIDTH-1:0]         nextData,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] nextPtr_s;

    // Entry storage: written at the tail on an accepted push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push && !flush) begin
            mem_r[wrPtr_r] <= pushData;
        end
    end

    // Pointers and count; the pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            wrPtr_r <= wrPtr_r + PTR_W'(push);
            rdPtr_r <= rdPtr_r + PTR_W'(popCount);
            count_r <= count_r + CNT_W'(push) - CNT_W'(popCount);
        end
    end

    assign nextPtr_s = rdPtr_r + PTR_W'(1);
    assign headData  = mem_r[rdPtr_r];
    assign nextData  = mem_r[nextPtr_s];
    assign count     = count_r;

endmodule

// File: rtl/lsu_issue_queue.sv
// LSU issue queue: buffers load/store micro-ops in order and issues up to two
// per cycle onto cache ports A (older) and B (younger), holding back B on a
// same-address conflict involving a store.
// Optional performance counters are built when LSU_PERF_CNT_EN is defined.
module lsu_issue_queue
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WB_W   = 5,
    parameter int unsigned OP_W   = 7
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              isWb_i,
    input  logic [WB_W-1:0]   wbAddress_i,
    input  logic [OP_W-1:0]   opCode_i,
    input  logic [ADDR_W-1:0] pOperand_i,
    input  logic [ADDR_W-1:0] sOperand_i,
    output logic              loadStoreA_o,
    output logic              loadStoreB_o,
    output logic              isWbA_o,
    output logic              isWbB_o,
    output logic [WB_W-1:0]   wbAddressA_o,
    output logic [WB_W-1:0]   wbAddressB_o,
    output logic [OP_W-1:0]   opCodeA_o,
    output logic [OP_W-1:0]   opCodeB_o,
    output logic [ADDR_W-1:0] pOperandA_o,
    output logic [ADDR_W-1:0] pOperandB_o,
    output logic [ADDR_W-1:0] sOperandA_o,
    output logic [ADDR_W-1:0] sOperandB_o,
    output logic [31:0]       issueCount_o,
    output logic [31:0]       blockCount_o
);

    localparam int unsigned ENTRY_W = entryWidth(ADDR_W, WB_W, OP_W);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned P_OFF   = pOperandOffset(ADDR_W);
    localparam int unsigned OP_OFF  = opCodeOffset(ADDR_W);
    localparam int unsigned WB_OFF  = wbAddressOffset(ADDR_W, OP_W);
    localparam int unsigned ISWB_OFF = isWbOffset(ADDR_W, OP_W, WB_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] pushData_s;
    logic [ENTRY_W-1:0] headData_s;
    logic [ENTRY_W-1:0] nextData_s;
    logic [CNT_W-1:0]   count_s;
    logic               push_s;
    logic [1:0]         popCount_s;
    logic               issueA_s;
    logic               issueB_s;
    logic               conflict_s;

    logic               headIsWb_s;
    logic [WB_W-1:0]    headWb_s;
    logic [OP_W-1:0]    headOp_s;
    logic [ADDR_W-1:0]  headP_s;
    logic [ADDR_W-1:0]  headS_s;
    logic               nextIsWb_s;
    logic [WB_W-1:0]    nextWb_s;
    logic [OP_W-1:0]    nextOp_s;
    logic [ADDR_W-1:0]  nextP_s;
    logic [ADDR_W-1:0]  nextS_s;

    // ready is taken from the registered count only: a full queue refuses even if it drains this edge.
    assign ready_o    = (count_s < CNT_FULL);
    assign push_s     = valid_i && ready_o && !flush_i;
    assign pushData_s = {isWb_i, wbAddress_i, opCode_i, pOperand_i, sOperand_i};

    lsu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) fifo (
        .clock    (clock_i),
        .reset    (reset_i),
        .flush    (flush_i),
        .push     (push_s),
        .pushData (pushData_s),
        .popCount (popCount_s),
        .headData (headData_s),
        .nextData (nextData_s),
        .count    (count_s)
    );

    assign headIsWb_s = headData_s[ISWB_OFF];
    assign headWb_s   = headData_s[WB_OFF +: WB_W];
    assign headOp_s   = headData_s[OP_OFF +: OP_W];
    assign headP_s    = headData_s[P_OFF +: ADDR_W];
    assign headS_s    = headData_s[0 +: ADDR_W];
    assign nextIsWb_s = nextData_s[ISWB_OFF];
    assign nextWb_s   = nextData_s[WB_OFF +: WB_W];
    assign nextOp_s   = nextData_s[OP_OFF +: OP_W];
    assign nextP_s    = nextData_s[P_OFF +: ADDR_W];
    assign nextS_s    = nextData_s[0 +: ADDR_W];

    assign conflict_s = hasConflict(32'(headOp_s), 32'(nextOp_s), headS_s == nextS_s);

    // Issue selection: A takes the head, B takes head+1 only alongside A and without a conflict.
    always_comb begin
        issueA_s = 1'b0;
        issueB_s = 1'b0;
        if (!stall_i && !flush_i) begin
            issueA_s = (count_s >= CNT_ONE);
            issueB_s = (count_s >= CNT_TWO) && !conflict_s;
        end else begin
            issueA_s = 1'b0;
            issueB_s = 1'b0;
        end
    end

    assign popCount_s = {issueB_s, issueA_s & ~issueB_s};

    // Registered issue ports; a non-issuing port drives all-zero fields.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            loadStoreA_o <= 1'b0;
            isWbA_o      <= 1'b0;
            wbAddressA_o <= {WB_W{1'b0}};
            opCodeA_o    <= {OP_W{1'b0}};
            pOperandA_o  <= {ADDR_W{1'b0}};
            sOperandA_o  <= {ADDR_W{1'b0}};
            loadStoreB_o <= 1'b0;
            isWbB_o      <= 1'b0;
            wbAddressB_o <= {WB_W{1'b0}};
            opCodeB_o    <= {OP_W{1'b0}};
            pOperandB_o  <= {ADDR_W{1'b0}};
            sOperandB_o  <= {ADDR_W{1'b0}};
        end else begin
            loadStoreA_o <= issueA_s;
            isWbA_o      <= issueA_s & headIsWb_s;
            wbAddressA_o <= issueA_s ? headWb_s : {WB_W{1'b0}};
            opCodeA_o    <= issueA_s ? headOp_s : {OP_W{1'b0}};
            pOperandA_o  <= issueA_s ? headP_s  : {ADDR_W{1'b0}};
            sOperandA_o  <= issueA_s ? headS_s  : {ADDR_W{1'b0}};
            loadStoreB_o <= issueB_s;
            isWbB_o      <= issueB_s & nextIsWb_s;
            wbAddressB_o <= issueB_s ? nextWb_s : {WB_W{1'b0}};
            opCodeB_o    <= issueB_s ? nextOp_s : {OP_W{1'b0}};
            pOperandB_o  <= issueB_s ? nextP_s  : {ADDR_W{1'b0}};
            sOperandB_o  <= issueB_s ? nextS_s  : {ADDR_W{1'b0}};
        end
    end

`ifdef LSU_PERF_CNT_EN
    logic [31:0] issueCount_r;
    logic [31:0] blockCount_r;
    logic        blockEvent_s;

    assign blockEvent_s = !stall_i && !flush_i && (count_s >= CNT_TWO) && conflict_s;

    // Performance counters: wrap at 2^32, survive flush, cleared only by reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            issueCount_r <= 32'd0;
            blockCount_r <= 32'd0;
        end else begin
            issueCount_r <= issueCount_r + {30'd0, popCount_s};
            blockCount_r <= blockCount_r + {31'd0, blockEvent_s};
        end
    end

    assign issueCount_o = issueCount_r;
    assign blockCount_o = blockCount_r;
`else
    assign issueCount_o = 32'd0;
    assign blockCount_o = 32'd0;
`endif

endmodule
